// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the MEM stage and an auxiliary requester.
// Fixed CPU priority with aux anti-starvation, access timeout and sticky err.
module dmem_arbiter #(
  parameter int TIMEOUT      = 15,
  parameter int AUX_WAIT_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        aux_req,
  input  logic        aux_we,
  input  logic [15:0] aux_addr,
  input  logic [15:0] aux_wdata,
  output logic        aux_gnt,
  output logic        aux_done,
  output logic [15:0] aux_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  output logic        err
);

  localparam int WW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [WW-1:0] TLAST = WW'(TIMEOUT - 1);
  localparam logic [2:0] SMAX = 3'(AUX_WAIT_MAX);

  typedef enum logic [1:0] {
    IDLE,
    CPU_ACC,
    AUX_ACC,
    CPU_DONE
  } state_t;

  state_t        state, state_n;
  logic [WW-1:0] wait_cnt, wait_n;
  logic [2:0]    starve_cnt, starve_n;
  logic          mem_en_n, mem_we_n;
  logic [15:0]   mem_addr_n, mem_wdata_n;
  logic [15:0]   cpu_rdata_n, aux_rdata_n;
  logic          aux_gnt_n, aux_done_n, err_n;
  logic          cpu_req, starved, finish;
  logic [15:0]   rdata;

  assign cpu_req   = cpu_rd | cpu_wr;
  assign starved   = aux_req && (starve_cnt == SMAX);
  assign cpu_stall = cpu_req && (state != CPU_DONE);
  assign finish    = mem_ready || (wait_cnt == TLAST);
  assign rdata     = mem_ready ? mem_rdata : 16'hFFFF;

  always_comb begin
    state_n     = state;
    wait_n      = wait_cnt;
    starve_n    = starve_cnt;
    mem_en_n    = mem_en;
    mem_we_n    = mem_we;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    cpu_rdata_n = cpu_rdata;
    aux_rdata_n = aux_rdata;
    aux_gnt_n   = aux_gnt;
    aux_done_n  = 1'b0;
    err_n       = err;
    unique case (state)
      IDLE: begin
        if (cpu_req && !starved) begin
          state_n     = CPU_ACC;
          wait_n      = '0;
          mem_en_n    = 1'b1;
          mem_we_n    = cpu_wr;
          mem_addr_n  = cpu_addr;
          mem_wdata_n = cpu_wdata;
          if (aux_req && starve_cnt != SMAX)
            starve_n = starve_cnt + 3'd1;
        end else if (aux_req) begin
          state_n     = AUX_ACC;
          wait_n      = '0;
          starve_n    = '0;
          aux_gnt_n   = 1'b1;
          mem_en_n    = 1'b1;
          mem_we_n    = aux_we;
          mem_addr_n  = aux_addr;
          mem_wdata_n = aux_wdata;
        end
      end
      CPU_ACC, AUX_ACC: begin
        if (finish) begin
          mem_en_n = 1'b0;
          mem_we_n = 1'b0;
          if (!mem_ready)
            err_n = 1'b1;
          if (state == CPU_ACC) begin
            state_n     = CPU_DONE;
            cpu_rdata_n = rdata;
          end else begin
            state_n     = IDLE;
            aux_rdata_n = rdata;
            aux_done_n  = 1'b1;
            aux_gnt_n   = 1'b0;
          end
        end else begin
          wait_n = wait_cnt + 1'b1;
        end
      end
      CPU_DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      starve_cnt <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_rdata  <= '0;
      aux_rdata  <= '0;
      aux_gnt    <= 1'b0;
      aux_done   <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_n;
      wait_cnt   <= wait_n;
      starve_cnt <= starve_n;
      mem_en     <= mem_en_n;
      mem_we     <= mem_we_n;
      mem_addr   <= mem_addr_n;
      mem_wdata  <= mem_wdata_n;
      cpu_rdata  <= cpu_rdata_n;
      aux_rdata  <= aux_rdata_n;
      aux_gnt    <= aux_gnt_n;
      aux_done   <= aux_done_n;
      err        <= err_n;
    end
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameters SHALL be:
- TIMEOUT, default 15: max cycles awaiting mem_ready before abort.
- AUX_WAIT_MAX, default 4: CPU grants tolerated while aux_req pending.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_rd  in  1  MEM-stage read request, from EX/MEM memread.
- cpu_wr  in  1  MEM-stage write request, from EX/MEM memwrite.
- cpu_addr  in  16  MEM-stage address, from EX/MEM ALU result.
- cpu_wdata  in  16  MEM-stage store data, from EX/MEM RD2.
- cpu_rdata  out  16  load data returned to the pipeline.
- cpu_stall  out  1  freezes the pipeline registers.
- aux_req  in  1  secondary requester (loader/DMA) request; held until aux_done.
- aux_we  in  1  aux write when 1, read when 0.
- aux_addr  in  16  aux address.
- aux_wdata  in  16  aux write data.
- aux_gnt  out  1  aux owns the memory.
- aux_done  out  1  one-cycle aux completion pulse.
- aux_rdata  out  16  aux read data.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  16  memory address.
- mem_wdata  out  16  memory write data.
- mem_rdata  in  16  memory read data.
- mem_ready  in  1  memory completion.
- err  out  1  sticky timeout flag.

Function
REQ-003 The FSM SHALL have four states: IDLE, CPU_ACC, AUX_ACC, CPU_DONE; all outputs except cpu_stall SHALL be registered.
REQ-004 In IDLE, the arbiter SHALL grant by fixed priority:
- CPU request (cpu_rd|cpu_wr) -> CPU_ACC, unless aux_req=1 and starve_cnt==AUX_WAIT_MAX.
- Otherwise aux_req=1 -> AUX_ACC.
- Otherwise stay in IDLE.
REQ-005 On grant, the arbiter SHALL latch the winner's address, write data and write flag into mem_addr/mem_wdata/mem_we, and SHALL drive mem_en=1 from the first cycle in the ACC state.
REQ-006 If cpu_rd and cpu_wr are both 1, the access SHALL be a write.
REQ-007 In an ACC state, when mem_ready=1 the FSM SHALL drop mem_en and mem_we on the next edge:
- CPU_ACC -> CPU_DONE, with cpu_rdata <= mem_rdata (writes also capture it).
- AUX_ACC -> IDLE, with aux_rdata <= mem_rdata and a single aux_done pulse.
REQ-008 CPU_DONE SHALL last exactly one cycle and then go to IDLE; the pipeline advances at the end of that cycle.
REQ-009 cpu_stall SHALL be combinational: (cpu_rd|cpu_wr) AND state!=CPU_DONE. With a 1-cycle memory, a CPU access therefore stalls 2 cycles.
REQ-010 aux_gnt SHALL equal 1 exactly while the state is AUX_ACC.
REQ-011 starve_cnt (3 bits) SHALL behave as follows:
- increment on each CPU grant made while aux_req=1, saturating at AUX_WAIT_MAX;
- clear on an aux grant;
- hold otherwise.
REQ-012 A wait counter SHALL clear on entry to an ACC state and increment each ACC cycle with mem_ready=0. On reaching TIMEOUT, the access SHALL abort:
- mem_en and mem_we go to 0 and err is set to 1;
- a CPU access goes to CPU_DONE with cpu_rdata=16'hFFFF;
- an aux access goes to IDLE with aux_done pulsed and aux_rdata=16'hFFFF.
REQ-013 mem_ready SHALL be ignored in IDLE and CPU_DONE.
REQ-014 Changes on cpu_* or aux_* inputs during an access SHALL NOT alter the latched mem_addr, mem_wdata or mem_we.
REQ-015 A new grant SHALL NOT occur in the same cycle as a completion; at least one IDLE cycle separates accesses.

Reset
REQ-016 While reset=0 the block SHALL, asynchronously:
- force the state to IDLE;
- clear mem_en, mem_we, mem_addr, mem_wdata, cpu_rdata, aux_rdata, aux_gnt, aux_done, err, starve_cnt and the wait counter to 0.
REQ-017 A reset asserted mid-access SHALL abort the access immediately with no aux_done pulse. cpu_stall SHALL continue to follow (cpu_rd|cpu_wr) during reset.
REQ-018 err SHALL clear only on reset.

Verification
REQ-019 CPU read, addr 16'h0040, mem_ready 1 cycle after mem_en, mem_rdata 16'hBEEF -> cpu_stall high 2 cycles; cpu_rdata=16'hBEEF in the CPU_DONE cycle.
REQ-020 cpu_wr and aux_req raised in the same cycle -> CPU granted first; aux_gnt rises one cycle after CPU_DONE ends.
REQ-021 Back-to-back CPU requests, aux_req held continuously -> after 4 CPU grants the aux access is granted next; starve_cnt returns to 0.
REQ-022 mem_ready held at 0 -> abort after 15 ACC cycles; cpu_rdata=16'hFFFF; err=1 and sticky until reset.
REQ-023 reset driven low in the second AUX_ACC cycle -> mem_en=0 and aux_gnt=0 without waiting for a clock edge; no aux_done; state IDLE after release.
